// File: rtl/gps_capture_pkg.sv
// Shared types and constants for the baseband snapshot buffer.
// Define BASEBAND_CAPTURE_TRIG_EN to add the external-trigger ARMED state.
package gps_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SAMPLES_PER_WORD = 5;
    localparam int SAMPLE_W         = 3;
    localparam int TAG_W            = 2;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port DEPTH x 32 buffer: one write port, registered read-first read port.
// Only the read register is reset; the array itself holds whatever was last written.
module capture_ram #(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the same array gives old data on a same-address collision.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/baseband_capture.sv
// Packs 3-bit I/Q samples five per word and captures a programmed number of words on start.
// Optional BASEBAND_CAPTURE_TRIG_EN: start arms, first trig cycle begins the fill.
module baseband_capture
    import gps_capture_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          sample_valid,
    input  logic [2:0]    real_in,
    input  logic [2:0]    imag_in,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   len_words,
`ifdef BASEBAND_CAPTURE_TRIG_EN
    input  logic          trig,
`endif
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   wr_count
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [2:0]  LAST_SLOT = 3'(SAMPLES_PER_WORD - 1);

    state_t               state;
    logic [2:0]           slot;
    logic [23:0]          acc;
    logic [AW:0]          len_lat;
    logic [AW:0]          eff_len;
    logic [2*SAMPLE_W-1:0] smp;
    logic                 accept;
    logic                 we;
    logic [31:0]          wdata;

    assign smp     = {real_in, imag_in};
    assign eff_len = (len_words == '0 || len_words > DEPTH_W) ? DEPTH_W : len_words;

    // The trigger cycle's own sample is slot 0 of word 0, so ARMED+trig accepts too.
`ifdef BASEBAND_CAPTURE_TRIG_EN
    assign accept = sample_valid && !abort &&
                    (state == ST_FILL || (state == ST_ARMED && trig));
`else
    assign accept = sample_valid && !abort && (state == ST_FILL);
`endif

    assign we    = aresetn && accept && (slot == LAST_SLOT);
    assign wdata = {wr_count[TAG_W-1:0], smp, acc};

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            slot     <= '0;
            acc      <= '0;
            len_lat  <= '0;
            wr_count <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (abort) begin
            state <= ST_IDLE;
            slot  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done     <= 1'b0;
                        wr_count <= '0;
                        slot     <= '0;
                        len_lat  <= eff_len;
                        busy     <= 1'b1;
`ifdef BASEBAND_CAPTURE_TRIG_EN
                        state    <= ST_ARMED;
`else
                        state    <= ST_FILL;
`endif
                    end
                end
`ifdef BASEBAND_CAPTURE_TRIG_EN
                ST_ARMED: begin
                    if (trig) begin
                        state <= ST_FILL;
                    end
                end
`endif
                default: ;
            endcase

            if (accept) begin
                if (slot == LAST_SLOT) begin
                    slot     <= '0;
                    wr_count <= wr_count + 1'b1;
                    if (wr_count + 1'b1 == len_lat) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end else begin
                    acc[2*SAMPLE_W*int'(slot) +: 2*SAMPLE_W] <= smp;
                    slot <= slot + 1'b1;
                end
            end
        end
    end

    capture_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .aresetn (aresetn),
        .we      (we),
        .waddr   (wr_count[AW-1:0]),
        .wdata   (wdata),
        .raddr   (rd_addr),
        .rdata   (rd_data)
    );

endmodule
